// File: rtl/conv_tile_engine_if.sv
// conv_tile_engine_if: start/busy/done handshake plus input, kernel and result matrices.
//   master drives start, inpMatrixI and kernel, and observes busy, done and convOut.
//   slave is the engine side of the same signals.
interface conv_tile_engine_if #(
    parameter int SIZE      = 6,
    parameter int SIZEKER   = 3,
    parameter int WIDTH_BIT = 8
);
    localparam int OUT = SIZE - SIZEKER + 1;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE];
    logic signed [WIDTH_BIT-1:0] kernel     [SIZEKER][SIZEKER];
    logic signed [WIDTH_BIT-1:0] convOut    [OUT][OUT];
    modport master (output start, inpMatrixI, kernel, input busy, done, convOut);
    modport slave  (input start, inpMatrixI, kernel, output busy, done, convOut);
endinterface

// File: rtl/conv_tile_engine.sv
// conv_tile_engine: tiled 2-D valid convolution, TILES*TILES MAC lanes, one kernel tap per cycle.
//   clock  : rising-edge clock
//   nreset : synchronous active-low reset; aborts a run and clears convOut
//   bus    : slave side of conv_tile_engine_if (start/busy/done, inpMatrixI, kernel, convOut)
module conv_tile_engine #(
    parameter int SIZE      = 6,
    parameter int SIZEKER   = 3,
    parameter int WIDTH_BIT = 8,
    parameter int TILES     = 2,
    parameter int SHIFT     = 0,
    parameter int RELU_EN   = 1
) (
    input logic              clock,
    input logic              nreset,
    conv_tile_engine_if.slave bus
);
    localparam int OUT = SIZE - SIZEKER + 1;
    localparam int TS  = OUT / TILES;
    localparam int AW  = 2 * WIDTH_BIT + $clog2(SIZEKER * SIZEKER) + 1;
    localparam int KW  = SIZEKER > 1 ? $clog2(SIZEKER) : 1;
    localparam int TW  = TS > 1 ? $clog2(TS) : 1;
    localparam int RW  = SIZE > 1 ? $clog2(SIZE) : 1;
    localparam logic signed [AW-1:0] SMAX = {{(AW-WIDTH_BIT+1){1'b0}}, {(WIDTH_BIT-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-WIDTH_BIT+1){1'b1}}, {(WIDTH_BIT-1){1'b0}}};

    if (TS * TILES != OUT) begin : g_bad_tiles
        $fatal(1, "OUT must be a multiple of TILES");
    end

    typedef enum logic [2:0] {IDLE, LOAD, MAC, WRITE, DONE} state_t;

    state_t                      state;
    logic                        busy_q, done_q;
    logic [TW-1:0]               i, j;
    logic [KW-1:0]               k, l;
    logic signed [WIDTH_BIT-1:0] ker   [SIZEKER][SIZEKER];
    logic signed [WIDTH_BIT-1:0] res   [TILES][TILES];
    logic signed [WIDTH_BIT-1:0] out_q [OUT][OUT];

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.convOut = out_q;

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            l      <= '0;
            ker    <= '{default: '0};
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state  <= LOAD;
                    busy_q <= 1'b1;
                    ker    <= bus.kernel;
                    i      <= '0;
                    j      <= '0;
                end
                LOAD: begin
                    k     <= '0;
                    l     <= '0;
                    state <= MAC;
                end
                MAC: begin
                    l <= l == KW'(SIZEKER-1) ? '0 : l + 1'b1;
                    k <= l == KW'(SIZEKER-1) ? (k == KW'(SIZEKER-1) ? '0 : k + 1'b1) : k;
                    if (k == KW'(SIZEKER-1) && l == KW'(SIZEKER-1)) state <= WRITE;
                end
                WRITE: begin
                    j <= j == TW'(TS-1) ? '0 : j + 1'b1;
                    if (j == TW'(TS-1)) i <= i == TW'(TS-1) ? '0 : i + 1'b1;
                    if (j == TW'(TS-1) && i == TW'(TS-1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One lane per tile: all lanes share the position (i,j) and tap (k,l),
    // each offset by its own tile origin.
    for (genvar a = 0; a < TILES; a++) begin : g_row
        for (genvar b = 0; b < TILES; b++) begin : g_col
            logic [RW-1:0]        rr, cc;
            logic signed [AW-1:0] acc, prod, sh, v;
            always_comb begin
                rr   = RW'(k) + RW'(i) + RW'(a * TS);
                cc   = RW'(l) + RW'(j) + RW'(b * TS);
                prod = AW'(bus.inpMatrixI[rr][cc]) * AW'(ker[k][l]);
                sh   = acc >>> SHIFT;
                v    = (RELU_EN != 0 && sh[AW-1]) ? '0 : sh;
            end
            assign res[a][b] = v > SMAX ? SMAX[WIDTH_BIT-1:0] : v < SMIN ? SMIN[WIDTH_BIT-1:0] : v[WIDTH_BIT-1:0];
            always_ff @(posedge clock) begin
                if (!nreset || state == LOAD) acc <= '0;
                else if (state == MAC) acc <= acc + prod;
            end
        end
    end

    // Each result element is owned by exactly one lane and one (i,j) position.
    for (genvar r = 0; r < OUT; r++) begin : g_out_r
        for (genvar c = 0; c < OUT; c++) begin : g_out_c
            always_ff @(posedge clock) begin
                if (!nreset) out_q[r][c] <= '0;
                else if (state == WRITE && i == TW'(r % TS) && j == TW'(c % TS)) out_q[r][c] <= res[r/TS][c/TS];
            end
        end
    end
endmodule

// File: tb/tb_conv_tile_engine.sv
// tb_conv_tile_engine: three engine configurations driven in lockstep, checked against a convolution model.
module tb_conv_tile_engine;
    logic clock = 1'b0;
    logic nreset = 1'b0;
    logic start = 1'b0;
    logic signed [7:0] inp [6][6];
    logic signed [7:0] ker [3][3];
    logic signed [7:0] mk  [3][3];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    conv_tile_engine_if b0 ();
    conv_tile_engine_if b1 ();
    conv_tile_engine_if b2 ();
    assign b0.start = start;
    assign b1.start = start;
    assign b2.start = start;
    assign b0.inpMatrixI = inp;
    assign b1.inpMatrixI = inp;
    assign b2.inpMatrixI = inp;
    assign b0.kernel = ker;
    assign b1.kernel = ker;
    assign b2.kernel = ker;

    conv_tile_engine d0 (.clock(clock), .nreset(nreset), .bus(b0.slave));
    conv_tile_engine #(.RELU_EN(0)) d1 (.clock(clock), .nreset(nreset), .bus(b1.slave));
    conv_tile_engine #(.SHIFT(2), .RELU_EN(0)) d2 (.clock(clock), .nreset(nreset), .bus(b2.slave));

    function automatic int model(int r, int c, int sh, bit relu);
        int s = 0;
        for (int k = 0; k < 3; k++)
            for (int l = 0; l < 3; l++)
                s += int'(inp[r+k][c+l]) * int'(mk[k][l]);
        s = s >>> sh;
        if (relu && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit zero);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                chk({tag, "_d0"}, int'(b0.convOut[r][c]), zero ? 0 : model(r, c, 0, 1));
                chk({tag, "_d1"}, int'(b1.convOut[r][c]), zero ? 0 : model(r, c, 0, 0));
                chk({tag, "_d2"}, int'(b2.convOut[r][c]), zero ? 0 : model(r, c, 2, 0));
            end
    endtask

    task automatic set_inp(input int v);
        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) inp[r][c] = 8'(v);
    endtask

    task automatic set_ker(input int v);
        for (int k = 0; k < 3; k++) for (int l = 0; l < 3; l++) ker[k][l] = 8'(v);
    endtask

    task automatic rand_inp();
        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) inp[r][c] = 8'($urandom);
    endtask

    task automatic rand_ker();
        for (int k = 0; k < 3; k++) for (int l = 0; l < 3; l++) ker[k][l] = 8'($urandom);
    endtask

    task automatic run(input string tag, input bit restart);
        int lat, bcnt;
        @(negedge clock);
        start = 1'b1;
        mk = ker;
        @(posedge clock);
        #1;
        start = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!b0.done && lat < 200) begin
            if (b0.busy) bcnt++;
            start = restart && (lat == 5 || lat == 20);
            if (restart && lat == 5) rand_ker();
            @(posedge clock);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, lat, 45);
        chk({tag, "_busy_cycles"}, bcnt, 44);
        chk({tag, "_busy_at_done"}, int'(b0.busy), 0);
        chk({tag, "_done_d1"}, int'(b1.done), 1);
        chk({tag, "_done_d2"}, int'(b2.done), 1);
        check_outs(tag, 1'b0);
        @(posedge clock);
        #1;
        chk({tag, "_done_pulse"}, int'(b0.done), 0);
        check_outs({tag, "_hold"}, 1'b0);
    endtask

    initial begin
        int dcnt;
        set_inp(0);
        set_ker(0);
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", int'(b0.busy), 0);
        chk("rst_done", int'(b0.done), 0);
        check_outs("rst", 1'b1);
        nreset = 1'b1;

        set_inp(1);
        set_ker(1);
        run("ones", 1'b0);
        chk("ones_val", int'(b0.convOut[3][3]), 9);
        chk("ones_shift", int'(b2.convOut[0][0]), 2);

        set_inp(127);
        set_ker(127);
        run("sat_pos", 1'b0);
        chk("sat_pos_val", int'(b0.convOut[1][2]), 127);

        set_ker(-128);
        run("sat_neg", 1'b0);
        chk("sat_neg_relu", int'(b0.convOut[2][1]), 0);
        chk("sat_neg_norelu", int'(b1.convOut[2][1]), -128);

        set_inp(1);
        set_ker(-1);
        run("floor", 1'b0);
        chk("floor_val", int'(b2.convOut[0][3]), -3);

        for (int r = 0; r < 6; r++) for (int c = 0; c < 6; c++) inp[r][c] = 8'(r * 6 + c);
        set_ker(0);
        ker[1][1] = 8'sd1;
        run("ident", 1'b0);
        for (int r = 0; r < 4; r++)
            chk("ident_val", int'(b0.convOut[r][3-r]), (r + 1) * 6 + (4 - r));

        for (int n = 0; n < 4; n++) begin
            rand_inp();
            rand_ker();
            run("rand", n == 1);
        end

        rand_inp();
        rand_ker();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clock);
        #1;
        nreset = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        nreset = 1'b1;
        start = 1'b0;
        chk("abort_busy", int'(b0.busy), 0);
        chk("abort_done", int'(b0.done), 0);
        check_outs("abort", 1'b1);
        dcnt = 0;
        repeat (60) begin
            @(posedge clock);
            #1;
            if (b0.done || b0.busy) dcnt++;
        end
        chk("abort_quiet", dcnt, 0);

        nreset = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        nreset = 1'b1;
        start = 1'b0;
        @(posedge clock);
        #1;
        chk("start_in_reset", int'(b0.busy), 0);

        rand_inp();
        rand_ker();
        run("after_abort", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv_tile_engine.md
CONV_TILE_ENGINE -- requirements
Module: conv_tile_engine

Interface
REQ-001 SHALL have parameter SIZE, default 6: input matrix edge length.
REQ-002 SHALL have parameter SIZEKER, default 3: kernel edge length.
REQ-003 SHALL have parameter WIDTH_BIT, default 8: signed element width for input, kernel and output.
REQ-004 SHALL have parameter TILES, default 2: lanes per dimension, giving TILES*TILES parallel MAC lanes.
REQ-005 SHALL have parameter SHIFT, default 0: arithmetic right-shift applied to each accumulated sum.
REQ-006 SHALL have parameter RELU_EN, default 1: 1 clamps negative results to 0; 0 passes them through.
REQ-007 SHALL define OUT = SIZE-SIZEKER+1 and TS = OUT/TILES; a non-integer TS is an elaboration error.
REQ-008 SHALL have port clock, input, 1 bit: single clock, all logic on the rising edge.
REQ-009 SHALL have port nreset, input, 1 bit: synchronous, active-low reset.
REQ-010 SHALL have port start, input, 1 bit: requests one full convolution.
REQ-011 SHALL have port inpMatrixI, input, signed [WIDTH_BIT-1:0] x [SIZE][SIZE]: input matrix, held stable while busy.
REQ-012 SHALL have port kernel, input, signed [WIDTH_BIT-1:0] x [SIZEKER][SIZEKER]: weights, captured at start.
REQ-013 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-014 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port convOut, output, signed [WIDTH_BIT-1:0] x [OUT][OUT]: result matrix.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, MAC, WRITE, DONE.
- IDLE->LOAD on start.
- LOAD->MAC.
- MAC->WRITE after SIZEKER*SIZEKER cycles.
- WRITE->LOAD if positions remain, else WRITE->DONE.
- DONE->IDLE.
REQ-017 SHALL accept start only in IDLE, register kernel into an internal copy on that edge, and ignore start in all other states.
REQ-018 SHALL partition output into TILES x TILES tiles of TS x TS; lane (a,b) computes convOut[a*TS+i][b*TS+j] for the shared row-major position counter (i,j).
REQ-019 SHALL in LOAD clear all lane accumulators and the tap counter.
REQ-020 SHALL in MAC process one tap (k,l) per cycle, row-major: acc += inpMatrixI[k+i+a*TS][l+j+b*TS] * kernel[k][l], in every lane.
REQ-021 SHALL size accumulators at 2*WIDTH_BIT+$clog2(SIZEKER*SIZEKER)+1 bits, signed, so they never overflow.
REQ-022 SHALL in WRITE compute each lane result in this order, then write it to its convOut element:
- acc >>> SHIFT (floor);
- ReLU if RELU_EN;
- saturate to [-2^(WIDTH_BIT-1), 2^(WIDTH_BIT-1)-1].
REQ-023 SHALL advance (i,j) in WRITE: j increments; on j==TS-1, j wraps to 0 and i increments; WRITE at (TS-1,TS-1) goes to DONE.
REQ-024 SHALL hold done=1 only in DONE, for exactly one cycle, with busy=0 in that cycle.
REQ-025 SHALL assert done exactly TS*TS*(SIZEKER*SIZEKER+2)+1 cycles after the edge sampling start (45 for defaults).
REQ-026 SHALL accept a start asserted during DONE only after returning to IDLE; back-to-back runs need start high in IDLE.
REQ-027 SHALL leave convOut elements unchanged except in WRITE; the previous results remain readable until overwritten.

Reset
REQ-028 SHALL on nreset=0 at a clock edge force: state=IDLE, busy=0, done=0, counters=0, accumulators=0, convOut all 0.
REQ-029 SHALL treat reset mid-operation as an abort: no done pulse, and convOut is cleared to 0.
REQ-030 SHALL ignore start in a cycle where nreset=0.

Verification
REQ-031 SHALL cover: defaults, input all 1, kernel all 1, start pulse -> done at cycle 45, all 16 convOut=9, busy high for cycles 1..44.
REQ-032 SHALL cover: input all 127, kernel all 127 -> all convOut=127 (saturation); input 127, kernel -128, RELU_EN=0 -> all -128; RELU_EN=1 -> all 0.
REQ-033 SHALL cover: SHIFT=2, RELU_EN=0, input all 1, kernel all -1 (sum -9) -> all convOut=-3 (floor).
REQ-034 SHALL cover: identity kernel (center 1, rest 0), input[r][c]=r*SIZE+c -> convOut[r][c]=input[r+1][c+1].
REQ-035 SHALL cover: start re-asserted at cycles 5 and 20 of a run -> ignored, done still at 45; kernel changed after start -> no effect.
REQ-036 SHALL cover: nreset low at cycle 20 -> next cycle busy=0, convOut all 0, no done; a fresh start then completes normally.
